// File: rtl/soc_addr_router_if.sv
// Core-side request/response bus of the address router.
//
// Signals:
//   req_valid / req_ready  request handshake (accepted when both are high)
//   req_addr               request address
//   req_we                 1 = write, 0 = read
//   req_wdata / req_be     write data and byte enables
//   rsp_valid              single-cycle response strobe (no backpressure)
//   rsp_rdata / rsp_err    read data and error flag, zero when rsp_valid is low
//
// Modports:
//   master  the core / bus adapter that issues requests
//   slave   the router that accepts them and returns responses
interface soc_addr_router_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 req_we;
  logic [DataWidth-1:0] req_wdata;
  logic [BeWidth-1:0]   req_be;

  logic                 rsp_valid;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/soc_addr_router.sv
// Parameter-driven address-map router: one core-side request port fanned out
// to NrSlaves downstream ports. Rule i maps to port i; addresses matching no
// enabled rule are answered by an internal decode-error responder.
// Outstanding transactions are tracked so responses return in order: a new
// target is only selected once every transaction to the previous one has
// completed.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   rule_en_i          per-rule enable, a disabled rule never matches
//   core               core-side request/response bus (slave modport)
//   mst_req_valid_o    per-port request valid (one-hot or zero)
//   mst_req_ready_i    per-port request ready
//   mst_req_addr_o, mst_req_we_o, mst_req_wdata_o, mst_req_be_o
//                      request fields broadcast to all ports
//   mst_rsp_valid_i    per-port response valid
//   mst_rsp_rdata_i    per-port read data, port i at [i*DataWidth +: DataWidth]
//   mst_rsp_err_i      per-port error flag
//   decerr_cnt_o       saturating count of decode errors
module soc_addr_router #(
  parameter int unsigned NrSlaves  = 5,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTrans  = 4,
  // Index 0 is the rightmost element: DRAM, PERIP, UART, CLINT, Debug.
  parameter logic [NrSlaves-1:0][AddrWidth-1:0] RuleBase = {
    64'h0000_0000_0000_0000,  // Debug
    64'h0000_0000_0200_0000,  // CLINT
    64'h0000_0000_1000_0000,  // UART
    64'h0000_0000_4000_0000,  // PERIP
    64'h0000_0000_8000_0000   // DRAM
  },
  parameter logic [NrSlaves-1:0][AddrWidth-1:0] RuleLength = {
    64'h0000_0000_0000_1000,  // Debug
    64'h0000_0000_000C_0000,  // CLINT
    64'h0000_0000_0000_1000,  // UART
    64'h0000_0000_2000_0000,  // PERIP
    64'h0000_0000_4000_0000   // DRAM
  },
  parameter logic [63:0] ErrRdata = 64'hBADC_AB1E_BADC_AB1E,
  localparam int unsigned BeWidth = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrSlaves-1:0]             rule_en_i,
  soc_addr_router_if.slave                core,
  output logic [NrSlaves-1:0]             mst_req_valid_o,
  input  logic [NrSlaves-1:0]             mst_req_ready_i,
  output logic [AddrWidth-1:0]            mst_req_addr_o,
  output logic                            mst_req_we_o,
  output logic [DataWidth-1:0]            mst_req_wdata_o,
  output logic [BeWidth-1:0]              mst_req_be_o,
  input  logic [NrSlaves-1:0]             mst_rsp_valid_i,
  input  logic [NrSlaves*DataWidth-1:0]   mst_rsp_rdata_i,
  input  logic [NrSlaves-1:0]             mst_rsp_err_i,
  output logic [15:0]                     decerr_cnt_o
);

  localparam int unsigned TgtW = $clog2(NrSlaves + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [TgtW-1:0] tgt_t;
  typedef logic [CntW-1:0] cnt_t;

  // The decode-error responder is addressed as one extra target past the
  // last real port.
  localparam tgt_t ErrTgt   = tgt_t'(NrSlaves);
  localparam cnt_t CntMax   = cnt_t'(MaxTrans);
  localparam logic [DataWidth-1:0] ErrData = DataWidth'(ErrRdata);

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  cnt_t        cnt_q, cnt_d;
  cnt_t        err_pend_q, err_pend_d;
  tgt_t        tgt_q, tgt_d;
  logic [15:0] decerr_q, decerr_d;

  tgt_t                 dec_tgt;
  logic                 dec_is_err;
  logic                 tgt_rdy;
  logic                 fwd;
  logic                 accept;
  logic                 port_vld;
  logic [DataWidth-1:0] port_rdata;
  logic                 port_err;
  logic                 real_rsp;
  logic                 err_rsp;
  logic                 rsp_fire;

  // Address decode. The offset is compared against the length rather than
  // comparing against base+length, which would wrap for rules near the top
  // of the address space. Scanning downwards lets the lowest index win.
  always_comb begin
    dec_tgt = ErrTgt;
    for (int i = NrSlaves - 1; i >= 0; i--) begin
      if (rule_en_i[i] && (core.req_addr >= RuleBase[i]) &&
          ((core.req_addr - RuleBase[i]) < RuleLength[i])) begin
        dec_tgt = tgt_t'(i);
      end
    end
  end

  assign dec_is_err = (dec_tgt == ErrTgt);

  // The error responder always accepts; real ports use their own ready.
  always_comb begin
    tgt_rdy = dec_is_err;
    for (int i = 0; i < NrSlaves; i++) begin
      if (dec_tgt == tgt_t'(i)) tgt_rdy = mst_req_ready_i[i];
    end
  end

  // A request may go out only while there is a free slot and it does not
  // switch targets with transactions still outstanding; otherwise responses
  // from two ports could overtake each other.
  assign fwd    = rst_ni && core.req_valid && (cnt_q < CntMax) &&
                  ((cnt_q == '0) || (dec_tgt == tgt_q));
  assign accept = fwd && tgt_rdy;

  assign core.req_ready = accept;

  always_comb begin
    mst_req_valid_o = '0;
    for (int i = 0; i < NrSlaves; i++) begin
      if (dec_tgt == tgt_t'(i)) mst_req_valid_o[i] = fwd;
    end
  end

  assign mst_req_addr_o  = rst_ni ? core.req_addr  : '0;
  assign mst_req_we_o    = rst_ni ? core.req_we    : 1'b0;
  assign mst_req_wdata_o = rst_ni ? core.req_wdata : '0;
  assign mst_req_be_o    = rst_ni ? core.req_be    : '0;

  // Only the port currently owning the outstanding transactions is listened
  // to; anything else on the response inputs is dropped.
  always_comb begin
    port_vld   = 1'b0;
    port_rdata = '0;
    port_err   = 1'b0;
    for (int i = 0; i < NrSlaves; i++) begin
      if (tgt_q == tgt_t'(i)) begin
        port_vld   = mst_rsp_valid_i[i];
        port_rdata = mst_rsp_rdata_i[i*DataWidth +: DataWidth];
        port_err   = mst_rsp_err_i[i];
      end
    end
  end

  assign real_rsp = (cnt_q != '0) && (tgt_q != ErrTgt) && port_vld;
  // Error responses come from registered state, so the first one appears
  // the cycle after the failing request was accepted.
  assign err_rsp  = (tgt_q == ErrTgt) && (err_pend_q != '0);
  assign rsp_fire = real_rsp || err_rsp;

  assign core.rsp_valid = rsp_fire;
  assign core.rsp_rdata = real_rsp ? port_rdata : (err_rsp ? ErrData : '0);
  assign core.rsp_err   = real_rsp ? port_err   : err_rsp;

  // A slot freed by a response in the same cycle as an accept cancels out.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept, rsp_fire})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    err_pend_d = err_pend_q;
    case ({accept && dec_is_err, err_rsp})
      2'b10:   err_pend_d = err_pend_q + cnt_t'(1);
      2'b01:   err_pend_d = err_pend_q - cnt_t'(1);
      default: err_pend_d = err_pend_q;
    endcase
  end

  assign tgt_d    = accept ? dec_tgt : tgt_q;
  assign decerr_d = (accept && dec_is_err) ? sat_inc16(decerr_q) : decerr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      err_pend_q <= '0;
      tgt_q      <= '0;
      decerr_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      tgt_q      <= tgt_d;
      decerr_q   <= decerr_d;
    end
  end

  assign decerr_cnt_o = decerr_q;

endmodule
